sysbus_arbiter: RTL and testbench

//  Shares the external multiplexed address/data memory bus between the CPU control unit and a

---
 rtl/sysbus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// Two-master arbiter and bus-cycle sequencer for the multiplexed address/data memory bus.
// Every pad strobe and handshake output is registered, decoded from the next state.
module sysbus_arbiter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned WAIT_STATES   = 1,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             CpuReq,
  input  logic             CpuWrite,
  input  logic [WIDTH-1:0] CpuAddr,
  input  logic [WIDTH-1:0] CpuWData,
  output logic             CpuGnt,
  output logic             CpuDone,
  input  logic             DmaReq,
  input  logic             DmaWrite,
  input  logic [WIDTH-1:0] DmaAddr,
  input  logic [WIDTH-1:0] DmaWData,
  output logic             DmaGnt,
  output logic             DmaDone,
  output logic [WIDTH-1:0] RData,
  input  logic [WIDTH-1:0] AdIn,
  output logic [WIDTH-1:0] AdOut,
  output logic             AdOe,
  output logic             ALE,
  output logic             ENB,
  output logic             nME,
  output logic             nOE,
  output logic             nWE
);

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned WCNT_W   = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                owner_q, owner_d;   // 1 = DMA owns the current access
  logic                write_q, write_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                dma_win;

  logic cpu_gnt_q, cpu_gnt_d, cpu_done_q, cpu_done_d;
  logic dma_gnt_q, dma_gnt_d, dma_done_q, dma_done_d;
  logic ale_q, ale_d, enb_q, enb_d, ad_oe_q, ad_oe_d;
  logic n_me_q, n_me_d, n_oe_q, n_oe_d, n_we_q, n_we_d;
  logic [WIDTH-1:0] ad_out_q, ad_out_d;

  // Next-state, arbitration and capture of the winning master's request
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    dma_win  = !CpuReq || (DmaReq && (starve_q == STARVE_W'(MAX_CPU_BURST)));
    case (state_q)
      S_IDLE: begin
        if (CpuReq || DmaReq) begin
          state_d = S_ADDR;
          owner_d = dma_win;
          write_d = dma_win ? DmaWrite : CpuWrite;
          addr_d  = dma_win ? DmaAddr  : CpuAddr;
          wdata_d = dma_win ? DmaWData : CpuWData;
          if (dma_win || !DmaReq) begin
            starve_d = '0;
          end else if (starve_q != STARVE_W'(MAX_CPU_BURST)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        if (WAIT_STATES == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!write_q) begin
          rdata_d = AdIn;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state being entered so the registered pins line up with it
  always_comb begin
    cpu_gnt_d  = 1'b0;
    cpu_done_d = 1'b0;
    dma_gnt_d  = 1'b0;
    dma_done_d = 1'b0;
    ale_d      = 1'b0;
    enb_d      = 1'b0;
    ad_oe_d    = 1'b0;
    ad_out_d   = '0;
    n_me_d     = 1'b1;
    n_oe_d     = 1'b1;
    n_we_d     = 1'b1;
    if (state_d != S_IDLE) begin
      cpu_gnt_d = !owner_d;
      dma_gnt_d = owner_d;
      n_me_d    = 1'b0;
    end
    case (state_d)
      S_ADDR: begin
        ale_d    = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_DATA, S_WAIT: begin
        if (write_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          n_we_d   = 1'b0;
        end else begin
          n_oe_d = 1'b0;
        end
      end
      S_DONE: begin
        cpu_done_d = !owner_d;
        dma_done_d = owner_d;
        if (write_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end else begin
          n_oe_d = 1'b0;
          enb_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      starve_q   <= '0;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpu_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_gnt_q  <= 1'b0;
      dma_done_q <= 1'b0;
      ale_q      <= 1'b0;
      enb_q      <= 1'b0;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      n_me_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cpu_gnt_q  <= cpu_gnt_d;
      cpu_done_q <= cpu_done_d;
      dma_gnt_q  <= dma_gnt_d;
      dma_done_q <= dma_done_d;
      ale_q      <= ale_d;
      enb_q      <= enb_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      n_me_q     <= n_me_d;
      n_oe_q     <= n_oe_d;
      n_we_q     <= n_we_d;
    end
  end

  assign CpuGnt  = cpu_gnt_q;
  assign CpuDone = cpu_done_q;
  assign DmaGnt  = dma_gnt_q;
  assign DmaDone = dma_done_q;
  assign RData   = rdata_q;
  assign AdOut   = ad_out_q;
  assign AdOe    = ad_oe_q;
  assign ALE     = ale_q;
  assign ENB     = enb_q;
  assign nME     = n_me_q;
  assign nOE     = n_oe_q;
  assign nWE     = n_we_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: two instances (one and zero wait states) share stimulus and are
// compared every cycle against an access-phase model, plus directed literal checks.
module tb_sysbus_arbiter;
  localparam int unsigned W    = 16;
  localparam int unsigned MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic cpu_req, cpu_wr, dma_req, dma_wr;
  logic [W-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, ad_in;
  logic [1:0] cpu_gnt, cpu_done, dma_gnt, dma_done, ad_oe, ale, enb, n_me, n_oe, n_we;
  logic [1:0][W-1:0] rdata, ad_out;

  sysbus_arbiter #(.WIDTH(W), .WAIT_STATES(1), .MAX_CPU_BURST(MAXB)) u_a (
    .Clock(clk), .nReset(rst_n),
    .CpuReq(cpu_req), .CpuWrite(cpu_wr), .CpuAddr(cpu_addr), .CpuWData(cpu_wdata),
    .CpuGnt(cpu_gnt[0]), .CpuDone(cpu_done[0]),
    .DmaReq(dma_req), .DmaWrite(dma_wr), .DmaAddr(dma_addr), .DmaWData(dma_wdata),
    .DmaGnt(dma_gnt[0]), .DmaDone(dma_done[0]),
    .RData(rdata[0]), .AdIn(ad_in), .AdOut(ad_out[0]), .AdOe(ad_oe[0]),
    .ALE(ale[0]), .ENB(enb[0]), .nME(n_me[0]), .nOE(n_oe[0]), .nWE(n_we[0])
  );

  sysbus_arbiter #(.WIDTH(W), .WAIT_STATES(0), .MAX_CPU_BURST(MAXB)) u_b (
    .Clock(clk), .nReset(rst_n),
    .CpuReq(cpu_req), .CpuWrite(cpu_wr), .CpuAddr(cpu_addr), .CpuWData(cpu_wdata),
    .CpuGnt(cpu_gnt[1]), .CpuDone(cpu_done[1]),
    .DmaReq(dma_req), .DmaWrite(dma_wr), .DmaAddr(dma_addr), .DmaWData(dma_wdata),
    .DmaGnt(dma_gnt[1]), .DmaDone(dma_done[1]),
    .RData(rdata[1]), .AdIn(ad_in), .AdOut(ad_out[1]), .AdOe(ad_oe[1]),
    .ALE(ale[1]), .ENB(enb[1]), .nME(n_me[1]), .nOE(n_oe[1]), .nWE(n_we[1])
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is a phase index k counted from ADDR (k=0) to DONE (k=ws+2)
  bit           m_busy [2];
  int           m_k    [2];
  bit           m_dma  [2];
  bit           m_wr   [2];
  logic [W-1:0] m_addr [2];
  logic [W-1:0] m_wd   [2];
  logic [W-1:0] m_rd   [2];
  int           m_starve [2];

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit dma_wins(int i);
    return !cpu_req || (dma_req && m_starve[i] == MAXB);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_k[i] <= 0; m_dma[i] <= 1'b0; m_wr[i] <= 1'b0;
        m_addr[i] <= '0; m_wd[i] <= '0; m_rd[i] <= '0; m_starve[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (cpu_req || dma_req) begin
            m_busy[i] <= 1'b1;
            m_k[i]    <= 0;
            m_dma[i]  <= dma_wins(i);
            m_wr[i]   <= dma_wins(i) ? dma_wr    : cpu_wr;
            m_addr[i] <= dma_wins(i) ? dma_addr  : cpu_addr;
            m_wd[i]   <= dma_wins(i) ? dma_wdata : cpu_wdata;
            m_starve[i] <= (dma_wins(i) || !dma_req) ? 0 :
                           ((m_starve[i] < MAXB) ? m_starve[i] + 1 : m_starve[i]);
          end
        end else if (m_k[i] == ws_of(i) + 2) begin
          m_busy[i] <= 1'b0;
          if (!m_wr[i]) m_rd[i] <= ad_in;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  function automatic logic [41:0] expect_out(int i);
    logic cg, cd, dg, dd, al, en, oe, me, noe, nwe;
    logic [W-1:0] ao;
    {cg, cd, dg, dd, al, en, oe} = '0;
    {me, noe, nwe} = 3'b111;
    ao = '0;
    if (m_busy[i]) begin
      cg = !m_dma[i];
      dg = m_dma[i];
      me = 1'b0;
      if (m_k[i] == 0) begin
        al = 1'b1; oe = 1'b1; ao = m_addr[i];
      end else if (m_k[i] <= ws_of(i) + 1) begin
        if (m_wr[i]) begin oe = 1'b1; ao = m_wd[i]; nwe = 1'b0; end
        else noe = 1'b0;
      end else begin
        cd = !m_dma[i];
        dd = m_dma[i];
        if (m_wr[i]) begin oe = 1'b1; ao = m_wd[i]; end
        else begin noe = 1'b0; en = 1'b1; end
      end
    end
    return {cg, cd, dg, dd, al, en, oe, me, noe, nwe, ao, m_rd[i]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "model_a" : "model_b",
            64'({cpu_gnt[i], cpu_done[i], dma_gnt[i], dma_done[i], ale[i], enb[i], ad_oe[i],
                 n_me[i], n_oe[i], n_we[i], ad_out[i], rdata[i]}),
            64'(expect_out(i)));
        chk(i == 0 ? "gnt_excl_a" : "gnt_excl_b", 64'(cpu_gnt[i] & dma_gnt[i]), 64'(0));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [9:0] seq;
  int seq_n;
  logic [3:0] vec [6];

  initial begin
    cpu_req = 0; cpu_wr = 0; dma_req = 0; dma_wr = 0;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0; ad_in = '0;
    #2 rst_n = 1'b0;
    cyc(2);
    chk("rst_nme", 64'(n_me[0]), 64'(1));
    chk("rst_gnt", 64'(cpu_gnt[0] | dma_gnt[0]), 64'(0));
    chk("rst_adoe", 64'(ad_oe[0]), 64'(0));
    rst_n = 1'b1;
    cyc(1);

    // CPU read with one wait state
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0100; ad_in = 16'hBEEF;
    cyc(1);
    chk("t1_ale", 64'(ale[0]), 64'(1));
    chk("t1_gnt", 64'(cpu_gnt[0]), 64'(1));
    chk("t1_addr", 64'(ad_out[0]), 64'(16'h0100));
    cyc(1);
    chk("t1_noe_c2", 64'(n_oe[0]), 64'(0));
    cyc(1);
    chk("t1_noe_c3", 64'(n_oe[0]), 64'(0));
    chk("t1_ws0_done_c3", 64'(cpu_done[1]), 64'(1));
    cyc(1);
    chk("t1_noe_c4", 64'(n_oe[0]), 64'(0));
    chk("t1_enb_c4", 64'(enb[0]), 64'(1));
    chk("t1_done_c4", 64'(cpu_done[0]), 64'(1));
    chk("t1_ws0_idle_c4", 64'(cpu_gnt[1]), 64'(0));
    cpu_req = 0;
    cyc(1);
    chk("t1_rdata", 64'(rdata[0]), 64'(16'hBEEF));
    chk("t1_done_gone", 64'(cpu_done[0]), 64'(0));
    cyc(3);

    // DMA write; inputs changed mid-access must be ignored
    dma_req = 1; dma_wr = 1; dma_addr = 16'h0040; dma_wdata = 16'h1234;
    cyc(1);
    chk("t2_ale", 64'(ale[0]), 64'(1));
    chk("t2_addr", 64'(ad_out[0]), 64'(16'h0040));
    chk("t2_gnt", 64'(dma_gnt[0]), 64'(1));
    dma_addr = 16'hFFFF; dma_wdata = 16'hFFFF;
    cyc(1);
    chk("t2_data", 64'(ad_out[0]), 64'(16'h1234));
    chk("t2_nwe_c2", 64'(n_we[0]), 64'(0));
    cyc(1);
    chk("t2_nwe_c3", 64'(n_we[0]), 64'(0));
    cyc(1);
    chk("t2_done", 64'(dma_done[0]), 64'(1));
    chk("t2_nwe_c4", 64'(n_we[0]), 64'(1));
    chk("t2_adoe_c4", 64'(ad_oe[0]), 64'(1));
    dma_req = 0;
    cyc(1);
    chk("t2_done_once", 64'(dma_done[0]), 64'(0));
    cyc(3);

    // Both masters requesting continuously: starvation limit forces DMA every fifth grant
    cpu_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0;
    seq = '0; seq_n = 0;
    for (int c = 0; c < 200 && seq_n < 10; c++) begin
      @(negedge clk);
      if (ale[0]) begin
        seq = {seq[8:0], dma_gnt[0]};
        seq_n++;
      end
    end
    chk("t3_count", 64'(seq_n), 64'(10));
    chk("t3_order", 64'(seq), 64'(10'b0000100001));
    cpu_req = 0; dma_req = 0;
    cyc(8);

    // CPU drops its request during DATA: access still completes, then the bus stays idle
    cpu_req = 1; cpu_wr = 0; ad_in = 16'h5A5A;
    cyc(2);
    cpu_req = 0;
    cyc(2);
    chk("t4_done", 64'(cpu_done[0]), 64'(1));
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      chk("t4_no_gnt", 64'(cpu_gnt[0] | dma_gnt[0]), 64'(0));
    end
    chk("t4_rdata", 64'(rdata[0]), 64'(16'h5A5A));

    // Reset asserted in WAIT of a CPU write
    cpu_req = 1; cpu_wr = 1; cpu_addr = 16'h0200; cpu_wdata = 16'hCAFE;
    cyc(3);
    chk("t5_nwe_wait", 64'(n_we[0]), 64'(0));
    rst_n = 1'b0;
    cpu_req = 0;
    #1;
    chk("t5_rst_bus", 64'({n_we[0], n_me[0], ad_oe[0], cpu_gnt[0]}), 64'(4'b1100));
    cyc(1);
    chk("t5_rst_rdata", 64'(rdata[0]), 64'(0));
    rst_n = 1'b1;
    cyc(1);
    dma_req = 1; dma_wr = 0; ad_in = 16'h7777;
    cyc(1);
    chk("t5_regrant", 64'({dma_gnt[0], ale[0]}), 64'(2'b11));
    cyc(3);
    chk("t5_done", 64'(dma_done[0]), 64'(1));
    dma_req = 0;
    cyc(1);
    chk("t5_rdata", 64'(rdata[0]), 64'(16'h7777));
    cyc(2);

    // Mixed request patterns {cpu_req, dma_req, cpu_wr, dma_wr}, model-checked on both instances
    vec[0] = 4'b1010; vec[1] = 4'b0101; vec[2] = 4'b1111;
    vec[3] = 4'b1100; vec[4] = 4'b0100; vec[5] = 4'b1001;
    for (int v = 0; v < 6; v++) begin
      {cpu_req, dma_req, cpu_wr, dma_wr} = vec[v];
      cpu_addr = W'(16'h1000 + v); cpu_wdata = W'(16'hA000 + v);
      dma_addr = W'(16'h2000 + v); dma_wdata = W'(16'hD000 + v);
      ad_in = W'(16'h3300 + v * 17);
      cyc(9);
    end
    cpu_req = 0; dma_req = 0;
    cyc(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
